// File: rtl/dmem_ctrl.sv
// Data-memory controller with valid/ready requests, fixed wait-state latency and
// byte/half/word access checking. Define DMEM_STATS_EN to add access counters.
module dmem_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]     stat_loads,
    output logic [31:0]     stat_stores,
    output logic [31:0]     stat_errs
`endif
);

    // state | meaning
    // IDLE  | no request in flight, ready to accept
    // WAIT  | request latched, counting down wait states
    // RESP  | response presented for one cycle, may accept the next request
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = XLEN / 8;
    localparam bit ZERO_LAT = (LATENCY == 0);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic accept, start;

    logic            l_we, l_uns;
    logic [1:0]      l_size;
    logic [XLEN-1:0] l_addr, l_wdata;

    logic            a_we, a_uns;
    logic [1:0]      a_size;
    logic [XLEN-1:0] a_addr, a_wdata;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] word_rd, lane, load_val, wmask, new_word, wdata_sh;
    logic [NB-1:0]   be;
    logic            err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (ZERO_LAT) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state != WAIT);
        rsp_valid = (state == RESP);
    end

    assign accept = req_valid && req_ready;
    // With zero latency the access happens on the acceptance edge itself, so use the live request.
    assign start  = reset && ((state == WAIT && cnt == 4'd0) || (accept && ZERO_LAT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_we    <= 1'b0;
            l_uns   <= 1'b0;
            l_size  <= 2'b00;
            l_addr  <= '0;
            l_wdata <= '0;
        end else if (accept) begin
            l_we    <= req_we;
            l_uns   <= req_unsigned;
            l_size  <= req_size;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
        end
    end

    always_comb begin
        a_we    = ZERO_LAT ? req_we       : l_we;
        a_uns   = ZERO_LAT ? req_unsigned : l_uns;
        a_size  = ZERO_LAT ? req_size     : l_size;
        a_addr  = ZERO_LAT ? req_addr     : l_addr;
        a_wdata = ZERO_LAT ? req_wdata    : l_wdata;
    end

    always_comb begin
        idx      = a_addr[AW+1:2];
        word_rd  = mem[idx];
        lane     = word_rd >> {a_addr[1:0], 3'b000};
        wdata_sh = a_wdata << {a_addr[1:0], 3'b000};
        err      = (a_size == 2'b11)
                || (a_size == 2'b01 && a_addr[0])
                || (a_size == 2'b10 && a_addr[1:0] != 2'b00)
                || (a_addr >= XLEN'(DEPTH_WORDS * 4));
        case (a_size)
            2'b00:   load_val = {{(XLEN-8){~a_uns & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{(XLEN-16){~a_uns & lane[15]}}, lane[15:0]};
            default: load_val = word_rd;
        endcase
        case (a_size)
            2'b00:   be = NB'(1) << a_addr[1:0];
            2'b01:   be = NB'(3) << a_addr[1:0];
            default: be = '1;
        endcase
        wmask = '0;
        for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{be[b]}};
        new_word = (word_rd & ~wmask) | (wdata_sh & wmask);
    end

    always_ff @(posedge clk) begin
        if (start && a_we && !err) mem[idx] <= new_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (start) begin
            rsp_err   <= err;
            rsp_rdata <= (err || a_we) ? '0 : load_val;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (start) begin
            if (err) begin
                if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
            end else if (a_we) begin
                if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
            end else begin
                if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised bench for dmem_ctrl: one instance at LATENCY=2, one at LATENCY=0,
// both checked against a byte-array reference model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic v2 = 0, we2 = 0, uns2 = 0, rdy2, rv2, re2;
    logic [1:0] sz2 = 0;
    logic [31:0] a2 = 0, wd2 = 0, rd2;
    logic v0 = 0, we0 = 0, uns0 = 0, rdy0, rv0, re0;
    logic [1:0] sz0 = 0;
    logic [31:0] a0 = 0, wd0 = 0, rd0;
`ifdef DMEM_STATS_EN
    logic [31:0] sl2, ss2, se2, sl0, ss0, se0;
`endif

    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(64), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
        .req_size(sz2), .req_unsigned(uns2), .req_addr(a2), .req_wdata(wd2),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2)
`ifdef DMEM_STATS_EN
        , .stat_loads(sl2), .stat_stores(ss2), .stat_errs(se2)
`endif
    );

    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_size(sz0), .req_unsigned(uns0), .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
`ifdef DMEM_STATS_EN
        , .stat_loads(sl0), .stat_stores(ss0), .stat_errs(se0)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int m_loads = 0, m_stores = 0, m_errs = 0;

    logic [7:0] mb2 [256];
    logic [7:0] mb0 [256];

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;
    req_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-addressed memory, alignment by modulo, extension by arithmetic.
    task automatic ref_access(input bit z, input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output bit err);
        int nb;
        longint v;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (addr % nb != 0) || (addr >= 32'd256);
        rd  = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) begin
                    if (z) mb0[int'(addr) + i] = 8'((wd >> (8 * i)) & 32'hFF);
                    else   mb2[int'(addr) + i] = 8'((wd >> (8 * i)) & 32'hFF);
                end
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++)
                    v += longint'(z ? mb0[int'(addr) + i] : mb2[int'(addr) + i]) << (8 * i);
                if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                    v -= (longint'(1) << (8 * nb));
                rd = v[31:0];
            end
        end
        if (!z) begin
            if (err)     m_errs++;
            else if (we) m_stores++;
            else         m_loads++;
        end
    endtask

    // Single transaction on the LATENCY=2 instance; entered and left on a negedge.
    task automatic txn2(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] er;
        bit ee;
        int n;
        ref_access(0, we, sz, uns, addr, wd, er, ee);
        chk("t2_ready_before", rdy2, 1);
        v2 = 1; we2 = we; sz2 = sz; uns2 = uns; a2 = addr; wd2 = wd;
        @(posedge clk);
        @(negedge clk);
        v2 = 0;
        chk("t2_ready_wait", rdy2, 0);
        chk("t2_valid_early", rv2, 0);
        n = 1;
        while (!rv2 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("t2_latency", n, 3);
        chk("t2_err", re2, ee);
        chk("t2_rdata", rd2, er);
    endtask

    // Streams q through the LATENCY=0 instance with req_valid held high.
    task automatic run_stream0();
        logic [31:0] prd, er;
        bit perr, ee, have;
        have = 0; prd = '0; perr = 0;
        foreach (q[k]) begin
            if (have) begin
                chk("s0_valid", rv0, 1);
                chk("s0_err", re0, perr);
                chk("s0_rdata", rd0, prd);
            end
            chk("s0_ready", rdy0, 1);
            v0 = 1; we0 = q[k].we; sz0 = q[k].size; uns0 = q[k].uns; a0 = q[k].addr; wd0 = q[k].wdata;
            ref_access(1, q[k].we, q[k].size, q[k].uns, q[k].addr, q[k].wdata, er, ee);
            prd = er; perr = ee; have = 1;
            @(posedge clk);
            @(negedge clk);
        end
        v0 = 0;
        if (have) begin
            chk("s0_valid", rv0, 1);
            chk("s0_err", re0, perr);
            chk("s0_rdata", rd0, prd);
        end
        @(negedge clk);
        chk("s0_valid_end", rv0, 0);
        q.delete();
    endtask

    function automatic req_t mk(input bit we, input logic [1:0] sz, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wd);
        req_t r;
        r.we = we; r.size = sz; r.uns = uns; r.addr = addr; r.wdata = wd;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r.uns   = 1'($urandom_range(0, 1));
        r.addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h10F));
        if ($urandom_range(0, 1) == 1 && r.size != 2'd3)
            r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
        r.wdata = $urandom;
        return r;
    endfunction

    initial begin
        req_t r;
        #2;
        chk("rst_ready2", rdy2, 1);
        chk("rst_valid2", rv2, 0);
        chk("rst_rdata2", rd2, 0);
        chk("rst_err2", re2, 0);
        chk("rst_ready0", rdy0, 1);
        chk("rst_valid0", rv0, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) txn2(1, 2'd2, 0, 32'(i * 4), $urandom);

        txn2(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        txn2(0, 2'd2, 0, 32'h10, 32'h0);
        txn2(1, 2'd2, 0, 32'h10, 32'h11223344);
        txn2(1, 2'd0, 0, 32'h13, 32'h80);
        txn2(0, 2'd2, 0, 32'h10, 32'h0);
        txn2(0, 2'd0, 0, 32'h13, 32'h0);
        txn2(0, 2'd0, 1, 32'h13, 32'h0);
        txn2(1, 2'd1, 0, 32'h21, 32'hBEEF);
        txn2(0, 2'd2, 0, 32'h20, 32'h0);
        txn2(0, 2'd2, 0, 32'h22, 32'h0);
        txn2(0, 2'd2, 0, 32'h100, 32'h0);
        txn2(0, 2'd2, 0, 32'hFC, 32'h0);
        txn2(0, 2'd1, 0, 32'hFFFF_FFFC, 32'h0);
        for (int i = 0; i < 60; i++) begin
            r = rand_req();
            txn2(r.we, r.size, r.uns, r.addr, r.wdata);
        end
`ifdef DMEM_STATS_EN
        chk("stat_loads", sl2, 32'(m_loads));
        chk("stat_stores", ss2, 32'(m_stores));
        chk("stat_errs", se2, 32'(m_errs));
`endif

        // Abort a store of 0x55 to 0x04 while it is waiting.
        chk("ab_ready", rdy2, 1);
        v2 = 1; we2 = 1; sz2 = 2'd2; uns2 = 0; a2 = 32'h04; wd2 = 32'h55;
        @(posedge clk);
        @(negedge clk);
        v2 = 0;
        chk("ab_in_wait", rdy2, 0);
        reset = 0;
        #1;
        chk("ab_ready_async", rdy2, 1);
        chk("ab_valid", rv2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ab_valid_hold", rv2, 0);
        end
        reset = 1;
        @(negedge clk);
        chk("ab_valid_after", rv2, 0);
        m_loads = 0; m_stores = 0; m_errs = 0;
`ifdef DMEM_STATS_EN
        chk("ab_stat_loads", sl2, 0);
        chk("ab_stat_stores", ss2, 0);
        chk("ab_stat_errs", se2, 0);
`endif
        txn2(0, 2'd2, 0, 32'h04, 32'h0);

        for (int i = 0; i < 64; i++) q.push_back(mk(1, 2'd2, 0, 32'(i * 4), $urandom));
        run_stream0();
        q.push_back(mk(1, 2'd2, 0, 32'h30, 32'hCAFEF00D));
        q.push_back(mk(0, 2'd2, 0, 32'h30, 32'h0));
        q.push_back(mk(1, 2'd1, 0, 32'h32, 32'h8001));
        q.push_back(mk(0, 2'd1, 0, 32'h32, 32'h0));
        run_stream0();
        for (int i = 0; i < 40; i++) q.push_back(rand_req());
        run_stream0();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
